// File: rtl/ofdm_tx_pkg.sv
// Shared types and defaults for the OFDM transmit cyclic-prefix path.
package ofdm_tx_pkg;

  localparam int DATA_W_DEF        = 32;
  localparam int MAX_NFFT_LOG2_DEF = 12;
  localparam int FS_W_DEF          = 32;
  localparam int MIN_NFFT_LOG2     = 3;

  typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_t;

  localparam logic [4:0] RST_NFFT_LOG2 = 5'd6;
  localparam int         RST_CP_LEN    = 0;
  localparam int         RST_FS_CYCLES = 1;

endpackage

// File: rtl/ofdm_cp_insert_if.sv
// AXI-Stream style sample bus; master drives data, slave drives ready.
interface ofdm_cp_insert_if
  import ofdm_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ofdm_pingpong_ram.sv
// Two symbol banks in one simple dual-port RAM; bank select is the address MSB.
// Read data is registered (1-cycle latency), no reset so it maps onto block RAM.
module ofdm_pingpong_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem_q [2**(AW+1)];
  logic [DATA_W-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank, wr_addr}] <= wr_dat;
    if (rd_en) rd_dat_q <= mem_q[{rd_bank, rd_addr}];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/ofdm_cp_insert.sv
// Buffers IFFT symbols in ping-pong banks and replays each as cyclic prefix + body,
// paced at one sample per fs_cycles clocks; output has no back-pressure.
module ofdm_cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_NFFT_LOG2 = MAX_NFFT_LOG2_DEF,
  parameter int FS_W          = FS_W_DEF
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            cfg_load,
  input  logic [4:0]      cfg_nfft_log2,
  input  logic [15:0]     cfg_cp_len,
  input  logic [FS_W-1:0] cfg_fs_cycles,
  ofdm_cp_insert_if.slave  s_axis,
  ofdm_cp_insert_if.master m_axis,
  output logic [15:0]     sym_count,
  output logic            err_tlast
);

  localparam int AW = MAX_NFFT_LOG2;
  localparam int NW = MAX_NFFT_LOG2 + 1;

  rd_state_t         state_q, state_d, first_state;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0]     wr_idx_q, wr_idx_d, rd_addr_q, rd_addr_d;
  logic [FS_W-1:0]   pace_q, pace_d, fs_m1_q, fs_m1_d;
  logic [4:0]        nfft_log2_q, nfft_log2_d, log2_c;
  logic [NW-1:0]     cp_len_q, cp_len_d, nfft, nfft_c;
  logic              vld_q, vld_d, last_q, last_d, err_q, err_d;
  logic [15:0]       sym_q, sym_d;
  logic [AW-1:0]     last_idx, first_addr;
  logic              wr_fire, wr_last, commit, tick, rel_bank, other_full, cfg_ok;
  logic [DATA_W-1:0] rd_dat;

  assign nfft        = NW'(1) << nfft_log2_q;
  assign last_idx    = AW'(nfft - NW'(1));
  assign first_state = (cp_len_q == '0) ? BODY : CP;
  assign first_addr  = (cp_len_q == '0) ? '0 : AW'(nfft - cp_len_q);

  assign s_axis.tready = !areset && !full_q[wr_bank_q];
  assign wr_fire       = s_axis.tvalid && s_axis.tready;
  assign wr_last       = (wr_idx_q == last_idx);
  assign commit        = wr_fire && wr_last;

  // Config is only accepted when nothing is buffered or in flight.
  always_comb begin
    nfft_log2_d = nfft_log2_q;
    cp_len_d    = cp_len_q;
    fs_m1_d     = fs_m1_q;
    cfg_ok      = cfg_load && (state_q == IDLE) && (full_q == 2'b00) && (wr_idx_q == '0);
    if (cfg_nfft_log2 < 5'(MIN_NFFT_LOG2))      log2_c = 5'(MIN_NFFT_LOG2);
    else if (cfg_nfft_log2 > 5'(MAX_NFFT_LOG2)) log2_c = 5'(MAX_NFFT_LOG2);
    else                                        log2_c = cfg_nfft_log2;
    nfft_c = NW'(1) << log2_c;
    if (cfg_ok) begin
      nfft_log2_d = log2_c;
      cp_len_d    = (cfg_cp_len > 16'(nfft_c)) ? nfft_c : NW'(cfg_cp_len);
      fs_m1_d     = (cfg_fs_cycles <= FS_W'(1)) ? '0 : cfg_fs_cycles - FS_W'(1);
    end
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    err_d     = err_q;
    if (wr_fire) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + AW'(1);
      if (s_axis.tlast != wr_last) err_d = 1'b1;
      if (wr_last) wr_bank_d = !wr_bank_q;
    end
  end

  // A bank committed this very cycle counts as full so back-to-back symbols have no gap.
  assign other_full = full_q[!rd_bank_q] || (commit && (wr_bank_q != rd_bank_q));

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    pace_d    = '0;
    tick      = 1'b0;
    rel_bank  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = first_state;
          rd_addr_d = first_addr;
        end
      end
      CP, BODY: begin
        pace_d = (pace_q == fs_m1_q) ? '0 : pace_q + FS_W'(1);
        tick   = (pace_q == '0);
        if (tick) begin
          if (rd_addr_q != last_idx) begin
            rd_addr_d = rd_addr_q + AW'(1);
          end else if (state_q == CP) begin
            state_d   = BODY;
            rd_addr_d = '0;
          end else begin
            rel_bank  = 1'b1;
            rd_bank_d = !rd_bank_q;
            state_d   = other_full ? first_state : IDLE;
            rd_addr_d = first_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (rel_bank) full_d[rd_bank_q] = 1'b0;
    if (commit)   full_d[wr_bank_q] = 1'b1;
    vld_d  = tick;
    last_d = tick && (state_q == BODY) && (rd_addr_q == last_idx);
    sym_d  = sym_q + {15'd0, last_d};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_addr_q   <= '0;
      pace_q      <= '0;
      nfft_log2_q <= RST_NFFT_LOG2;
      cp_len_q    <= NW'(RST_CP_LEN);
      fs_m1_q     <= FS_W'(RST_FS_CYCLES - 1);
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      sym_q       <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_addr_q   <= rd_addr_d;
      pace_q      <= pace_d;
      nfft_log2_q <= nfft_log2_d;
      cp_len_q    <= cp_len_d;
      fs_m1_q     <= fs_m1_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      err_q       <= err_d;
      sym_q       <= sym_d;
    end
  end

  ofdm_pingpong_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk     (aclk),
    .wr_en   (wr_fire),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_idx_q),
    .wr_dat  (s_axis.tdata),
    .rd_en   (tick),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr_q),
    .rd_dat  (rd_dat)
  );

  assign m_axis.tvalid = vld_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tdata  = vld_q ? rd_dat : '0;
  assign sym_count     = sym_q;
  assign err_tlast     = err_q;

endmodule
